// File: rtl/card_pkg.sv
// Shared deck constants, FSM encoding and card id decode helpers for the blackjack deck sequencer.
// Pure combinational helpers; no latency, no flow control.
package card_pkg;

   localparam int DECK_SIZE  = 52;
   localparam int RANK_COUNT = 13;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_DELIVER = 2'd2
   } state_t;

   // Four conditional subtractions cover every 6-bit id, so no divider is needed.
   function automatic logic [3:0] id_to_rank(input logic [5:0] id);
      logic [5:0] r;
      r = id;
      for (int i = 0; i < 4; i++) begin
         if (r >= 6'(RANK_COUNT)) begin
            r = r - 6'(RANK_COUNT);
         end
      end
      return 4'(r + 6'd1);
   endfunction

   function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
      return (rank > 4'd10) ? 4'd10 : rank;
   endfunction

endpackage

// File: rtl/card_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (period 63) that steps only while enabled.
// One-cycle update; the enable is the only flow control.
module card_lfsr #(
   parameter logic [5:0] SEED = 6'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [5:0] lfsr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (en) begin
         lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      end
   end

endmodule

// File: rtl/card_dealer.sv
// Round-robin deck sequencer: draws never-repeating cards from a used-card bitmap, indexed by an LFSR.
// Request to card_valid is 2 cycles plus 1 per rejected candidate; requests are latched, never dropped.
module card_dealer
   import card_pkg::*;
#(
   parameter logic [5:0] LFSR_SEED = 6'h01,
   parameter int         DECK_SIZE = card_pkg::DECK_SIZE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       player_req,
   input  logic       dealer_req,
   input  logic       shuffle,
   output logic       card_valid,
   output logic [5:0] card_id,
   output logic [3:0] card_rank,
   output logic [3:0] card_value,
   output logic       card_dest,
   output logic       err,
   output logic       busy,
   output logic [5:0] cards_left
);

   localparam logic [5:0] FULL = 6'(DECK_SIZE);

   state_t               state;
   state_t               state_nx;
   logic                 pend_p;
   logic                 pend_d;
   logic                 pend_s;
   logic                 rr;
   logic [DECK_SIZE-1:0] bitmap;
   logic [5:0]           lfsr;
   logic [5:0]           cand;
   logic                 cand_ok;
   logic [3:0]           cand_rank;
   logic [3:0]           cand_value;
   logic                 lfsr_en;
   logic                 want_p;
   logic                 want_d;
   logic                 want_s;
   logic                 do_shuffle;
   logic                 grant;
   logic                 grant_both;
   logic                 grant_dest;

   assign lfsr_en = (state == ST_SEARCH);

   card_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (lfsr_en),
      .lfsr (lfsr)
   );

   // The LFSR never reaches zero, so lfsr-1 spans ids 0..62 and visits each once per period.
   assign cand       = lfsr - 6'd1;
   assign cand_ok    = (cand < FULL) && !bitmap[cand];
   assign cand_rank  = id_to_rank(cand);
   assign cand_value = rank_to_value(cand_rank);

   assign want_p = pend_p | player_req;
   assign want_d = pend_d | dealer_req;
   assign want_s = pend_s | shuffle;
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      do_shuffle = 1'b0;
      grant      = 1'b0;
      grant_both = 1'b0;
      grant_dest = 1'b0;
      case (state)
         ST_IDLE: begin
            if (want_s) begin
               do_shuffle = 1'b1;
            end else if (want_p || want_d) begin
               grant      = 1'b1;
               grant_both = want_p & want_d;
               grant_dest = grant_both ? rr : want_d;
               if (cards_left != 6'd0) begin
                  state_nx = ST_SEARCH;
               end
            end
         end
         ST_SEARCH: begin
            if (cand_ok) begin
               state_nx = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Later assignments in this block deliberately override earlier ones: a clear wins over a same-cycle set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_p     <= 1'b0;
         pend_d     <= 1'b0;
         pend_s     <= 1'b0;
         rr         <= 1'b0;
         bitmap     <= '0;
         cards_left <= FULL;
         card_valid <= 1'b0;
         card_id    <= 6'd0;
         card_rank  <= 4'd0;
         card_value <= 4'd0;
         card_dest  <= 1'b0;
         err        <= 1'b0;
      end else begin
         card_valid <= 1'b0;
         err        <= 1'b0;

         if (player_req) pend_p <= 1'b1;
         if (dealer_req) pend_d <= 1'b1;
         if (shuffle)    pend_s <= 1'b1;

         if (do_shuffle) begin
            bitmap     <= '0;
            cards_left <= FULL;
            pend_s     <= 1'b0;
         end

         if (grant) begin
            card_dest <= grant_dest;
            if (grant_both) begin
               rr <= ~rr;
            end
            // Empty deck: answer with err immediately and retire the request.
            if (cards_left == 6'd0) begin
               err <= 1'b1;
               if (grant_dest) pend_d <= 1'b0;
               else            pend_p <= 1'b0;
            end
         end

         if (state == ST_SEARCH && cand_ok) begin
            card_valid <= 1'b1;
            card_id    <= cand;
            card_rank  <= cand_rank;
            card_value <= cand_value;
         end

         if (state == ST_DELIVER) begin
            bitmap[card_id] <= 1'b1;
            cards_left      <= cards_left - 6'd1;
            if (card_dest) pend_d <= 1'b0;
            else           pend_p <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: randomized draws compared against a deck/LFSR reference model.
module tb_card_dealer;

   logic       clk = 1'b0;
   logic       rst;
   logic       player_req;
   logic       dealer_req;
   logic       shuffle;
   logic       card_valid;
   logic [5:0] card_id;
   logic [3:0] card_rank;
   logic [3:0] card_value;
   logic       card_dest;
   logic       err;
   logic       busy;
   logic [5:0] cards_left;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: deck contents, LFSR value, cards remaining, round-robin side.
   int m_lfsr;
   bit m_used[52];
   int m_left;
   bit m_rr;

   card_dealer #(
      .LFSR_SEED (6'h01),
      .DECK_SIZE (52)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .player_req (player_req),
      .dealer_req (dealer_req),
      .shuffle    (shuffle),
      .card_valid (card_valid),
      .card_id    (card_id),
      .card_rank  (card_rank),
      .card_value (card_value),
      .card_dest  (card_dest),
      .err        (err),
      .busy       (busy),
      .cards_left (cards_left)
   );

   always #5 clk = ~clk;

   function automatic int lfsr_next(input int l);
      return ((l * 2) % 64) + (((l / 32) + (l / 16)) % 2);
   endfunction

   // Expected {card_valid, id, rank, value, dest} for a delivered card.
   function automatic logic [15:0] exp_card(input int id, input bit dest);
      int r;
      r = (id % 13) + 1;
      return {1'b1, 6'(id), 4'(r), 4'((r > 10) ? 10 : r), dest};
   endfunction

   task automatic model_reset();
      m_lfsr = 1;
      m_left = 52;
      m_rr   = 1'b0;
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
   endtask

   task automatic model_shuffle();
      m_left = 52;
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
   endtask

   // Walk the LFSR until an unused card turns up; every visited candidate costs one cycle.
   task automatic model_draw(output int id, output int rej);
      int c;
      rej = 0;
      c   = 0;
      for (int k = 0; k < 64; k++) begin
         c      = m_lfsr - 1;
         m_lfsr = lfsr_next(m_lfsr);
         if (c < 52) begin
            if (!m_used[c]) break;
         end
         rej++;
      end
      m_used[c] = 1'b1;
      m_left--;
      id = c;
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      player_req = 1'b0;
      dealer_req = 1'b0;
      shuffle    = 1'b0;
      rst        = 1'b1;
      step(2);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pulse(input bit p, input bit d, input bit s);
      @(posedge clk);
      #1;
      player_req = p;
      dealer_req = d;
      shuffle    = s;
      @(posedge clk);
      #1;
      player_req = 1'b0;
      dealer_req = 1'b0;
      shuffle    = 1'b0;
   endtask

   // Checks the current cycle first, then counts rising edges until card_valid or err.
   task automatic wait_event(output int n, output bit to);
      n  = 0;
      to = 1'b0;
      while (!(card_valid || err)) begin
         if (n >= 80) begin
            to = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic get_card(output int n, output bit to, output logic [15:0] obs);
      wait_event(n, to);
      obs = {card_valid, card_id, card_rank, card_value, card_dest};
      step(1);
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %0h want 0", busy);
      end
      n_cmp++;
      if (cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL reset_cards_left: got %0d want 52", cards_left);
      end
      n_cmp++;
      if ({card_valid, err, card_id, card_rank, card_value, card_dest} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h want 0",
                  {card_valid, err, card_id, card_rank, card_value, card_dest});
      end
   endtask

   task automatic test_single_draw();
      int id, rej, n;
      bit to;
      logic [15:0] obs;
      pulse(1'b1, 1'b0, 1'b0);
      model_draw(id, rej);
      get_card(n, to, obs);
      n_cmp++;
      if (to || n != 1 + rej) begin
         n_fail++;
         $display("FAIL single_latency: got %0d (timeout %0d) want %0d", n, to, 1 + rej);
      end
      n_cmp++;
      if (obs !== exp_card(0, 1'b0)) begin
         n_fail++;
         $display("FAIL single_card: got %0h want %0h", obs, exp_card(0, 1'b0));
      end
      n_cmp++;
      if (cards_left !== 6'd51 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_cards_left: got %0d busy %0d want 51 busy 0", cards_left, busy);
      end
   endtask

   task automatic test_sequence();
      int exp_ids[5] = '{1, 3, 7, 15, 32};
      int id, rej, n;
      bit to;
      logic [15:0] obs;
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1, 1'b0, 1'b0);
         model_draw(id, rej);
         get_card(n, to, obs);
         n_cmp++;
         if (to || n != 1 + rej) begin
            n_fail++;
            $display("FAIL seq_latency[%0d]: got %0d want %0d", i, n, 1 + rej);
         end
         n_cmp++;
         if (obs !== exp_card(exp_ids[i], 1'b0)) begin
            n_fail++;
            $display("FAIL seq_card[%0d]: got %0h want %0h", i, obs, exp_card(exp_ids[i], 1'b0));
         end
      end
   endtask

   task automatic test_round_robin();
      int id, rej, n;
      bit to, first;
      logic [15:0] obs;
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         pulse(1'b1, 1'b1, 1'b0);
         first = m_rr;
         m_rr  = ~m_rr;
         for (int c = 0; c < 2; c++) begin
            model_draw(id, rej);
            get_card(n, to, obs);
            n_cmp++;
            if (to || n != ((c == 0) ? 1 : 2) + rej) begin
               n_fail++;
               $display("FAIL rr_latency[%0d.%0d]: got %0d want %0d", k, c, n, ((c == 0) ? 1 : 2) + rej);
            end
            n_cmp++;
            if (obs !== exp_card(id, (c == 0) ? first : ~first)) begin
               n_fail++;
               $display("FAIL rr_card[%0d.%0d]: got %0h want %0h", k, c, obs,
                        exp_card(id, (c == 0) ? first : ~first));
            end
         end
      end
   endtask

   task automatic test_random();
      int id, rej, n, sel, cnt;
      bit to, first;
      logic [15:0] obs;
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         sel = $urandom_range(0, 2);
         step($urandom_range(0, 3));
         pulse(sel != 1, sel != 0, 1'b0);
         if (sel == 2) begin
            first = m_rr;
            m_rr  = ~m_rr;
            cnt   = 2;
         end else begin
            first = (sel == 1);
            cnt   = 1;
         end
         for (int c = 0; c < cnt; c++) begin
            model_draw(id, rej);
            get_card(n, to, obs);
            n_cmp++;
            if (to || n != ((c == 0) ? 1 : 2) + rej) begin
               n_fail++;
               $display("FAIL rand_latency[%0d.%0d]: got %0d want %0d", k, c, n, ((c == 0) ? 1 : 2) + rej);
            end
            n_cmp++;
            if (obs !== exp_card(id, (c == 0) ? first : ~first)) begin
               n_fail++;
               $display("FAIL rand_card[%0d.%0d]: got %0h want %0h", k, c, obs,
                        exp_card(id, (c == 0) ? first : ~first));
            end
         end
      end
   endtask

   task automatic test_exhaust();
      int id, rej, n;
      bit to, extra;
      bit seen[64];
      logic [15:0] obs;
      apply_reset();
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      for (int i = 0; i < 52; i++) begin
         step($urandom_range(0, 3));
         pulse(1'b1, 1'b0, 1'b0);
         model_draw(id, rej);
         get_card(n, to, obs);
         n_cmp++;
         if (to || n > 64 || n != 1 + rej || obs !== exp_card(id, 1'b0)) begin
            n_fail++;
            $display("FAIL deck_draw[%0d]: got %0h after %0d want %0h after %0d", i, obs, n,
                     exp_card(id, 1'b0), 1 + rej);
         end
         n_cmp++;
         if (seen[obs[14:9]]) begin
            n_fail++;
            $display("FAIL deck_unique[%0d]: got repeated id %0d want unused id", i, obs[14:9]);
         end
         seen[obs[14:9]] = 1'b1;
      end
      n_cmp++;
      if (cards_left !== 6'd0) begin
         n_fail++;
         $display("FAIL deck_empty: got %0d want 0", cards_left);
      end
      // Draw from an empty deck, once per side.
      for (int s = 0; s < 2; s++) begin
         pulse(s == 0, s == 1, 1'b0);
         wait_event(n, to);
         n_cmp++;
         if (to || n != 0 || {err, card_valid, card_dest} !== {2'b10, 1'(s)}) begin
            n_fail++;
            $display("FAIL empty_err[%0d]: got err %0d valid %0d dest %0d at %0d want 1 0 %0d at 0",
                     s, err, card_valid, card_dest, n, s);
         end
         extra = 1'b0;
         for (int c = 0; c < 4; c++) begin
            step(1);
            if (err || card_valid) extra = 1'b1;
         end
         n_cmp++;
         if (extra) begin
            n_fail++;
            $display("FAIL empty_single_err[%0d]: got extra pulse want none", s);
         end
      end
      pulse(1'b0, 1'b0, 1'b1);
      model_shuffle();
      n_cmp++;
      if (cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL shuffle_refill: got %0d want 52", cards_left);
      end
      pulse(1'b1, 1'b0, 1'b0);
      model_draw(id, rej);
      get_card(n, to, obs);
      n_cmp++;
      if (to || n != 1 + rej || obs !== exp_card(id, 1'b0)) begin
         n_fail++;
         $display("FAIL post_shuffle_draw: got %0h after %0d want %0h after %0d", obs, n,
                  exp_card(id, 1'b0), 1 + rej);
      end
   endtask

   task automatic test_shuffle_busy();
      int id, rej, n;
      bit to;
      logic [15:0] obs;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b1, 1'b0, 1'b0);
         model_draw(id, rej);
         get_card(n, to, obs);
      end
      @(posedge clk);
      #1;
      dealer_req = 1'b1;
      @(posedge clk);
      #1;
      dealer_req = 1'b0;
      shuffle    = 1'b1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL shbusy_busy: got %0d want 1", busy);
      end
      @(posedge clk);
      #1;
      shuffle = 1'b0;
      model_draw(id, rej);
      wait_event(n, to);
      obs = {card_valid, card_id, card_rank, card_value, card_dest};
      n_cmp++;
      if (to || n != rej || obs !== exp_card(id, 1'b1)) begin
         n_fail++;
         $display("FAIL shbusy_card: got %0h after %0d want %0h after %0d", obs, n, exp_card(id, 1'b1), rej);
      end
      step(1);
      n_cmp++;
      if (cards_left !== 6'(m_left)) begin
         n_fail++;
         $display("FAIL shbusy_delivered: got %0d want %0d", cards_left, m_left);
      end
      model_shuffle();
      step(1);
      n_cmp++;
      if (cards_left !== 6'd52) begin
         n_fail++;
         $display("FAIL shbusy_refill: got %0d want 52", cards_left);
      end
      pulse(1'b1, 1'b0, 1'b0);
      model_draw(id, rej);
      get_card(n, to, obs);
      n_cmp++;
      if (to || n != 1 + rej || obs !== exp_card(id, 1'b0)) begin
         n_fail++;
         $display("FAIL shbusy_next: got %0h after %0d want %0h after %0d", obs, n, exp_card(id, 1'b0), 1 + rej);
      end
   endtask

   task automatic test_reset_mid_search();
      int id, rej, n;
      bit to;
      logic [15:0] obs;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         pulse(1'b0, 1'b1, 1'b0);
         model_draw(id, rej);
         get_card(n, to, obs);
      end
      pulse(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstsearch_busy: got %0d want 1", busy);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      n_cmp++;
      if (busy !== 1'b0 || cards_left !== 6'd52 || card_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstsearch_state: got busy %0d left %0d valid %0d want 0 52 0", busy, cards_left, card_valid);
      end
      pulse(1'b1, 1'b0, 1'b0);
      model_draw(id, rej);
      get_card(n, to, obs);
      n_cmp++;
      if (to || n != 1 + rej || obs !== exp_card(0, 1'b0)) begin
         n_fail++;
         $display("FAIL rstsearch_seed: got %0h after %0d want %0h after %0d", obs, n, exp_card(0, 1'b0), 1 + rej);
      end
   endtask

   initial begin
      test_reset();
      test_single_draw();
      test_sequence();
      test_round_robin();
      test_random();
      test_exhaust();
      test_shuffle_busy();
      test_reset_mid_search();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want completion within 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
